if_id_stage: RTL
================

// Module: if_id_stage
// PURPOSE
//  Instruction-fetch front end plus IF/ID pipeline register; directly upstream of the decode stage that feeds ID_EX.
//  Owns the PC and a single-outstanding req/ack handshake to instruction memory.
//  Holds a 2-entry prefetch buffer that absorbs decode stalls.
//  Presents ins_out/nextAddress_out/valid_out to decode; honours stall, flush and branch/jump redirect.
// PARAMETERS
//  RESET_PC   32'h0000_3000   PC value loaded on reset
//  BUF_DEPTH  2               prefetch entries; fixed at 2, other values unsupported
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   asynchronous, active-low reset
//  imem_req         out  1   fetch request; held until accepted
//  imem_addr        out  32  fetch address; stable while imem_req=1
//  imem_ack         in   1   request accepted, imem_rdata valid this cycle
//  imem_rdata       in   32  fetched instruction word
//  stall            in   1   hazard unit: hold IF/ID register
//  flush            in   1   squash IF/ID register to bubble
//  redirect         in   1   branch/jump taken this cycle
//  redirect_pc      in   32  target PC when redirect=1
//  ins_out          out  32  instruction to decode (0 = nop on bubble)
//  nextAddress_out  out  32  fetch address + 4 of ins_out
//  valid_out        out  1   ins_out holds a real instruction
// BEHAVIOUR
//  Reset (reset=0, async):
//   pc=RESET_PC, FSM=IDLE, buffer empty, imem_req=0.
//   ins_out=0, nextAddress_out=0, valid_out=0.
//  Handshake:
//   - A transfer completes on an edge with imem_req&imem_ack; ack may arrive in the same cycle req rises.
//   - At most one transfer outstanding; imem_addr is a register, never changes while req=1.
//  FSM, registered states:
//   - IDLE: leaves on the first edge after reset release; goes to FETCH.
//   - FETCH: req=0; issues req with imem_addr=pc when buf_count<2; goes to WAIT.
//   - WAIT: req=1.
//     - On ack: push {imem_rdata, imem_addr+4} into the buffer, pc<=pc+4.
//     - Next state is WAIT with the next address if buf_count after push/pop <2, else FETCH.
//   - DROP: req=1, held with the old address. On ack, data is discarded; go to FETCH with the redirected pc.
//  Redirect (highest priority):
//   - pc<=redirect_pc and buffer cleared.
//   - If a transfer is outstanding and not acked this cycle, go to DROP.
//   - If acked this same cycle, the acked data is discarded and the FSM goes to FETCH.
//   - redirect in DROP updates pc again and stays in DROP.
//  IF/ID register, priority flush > stall > advance:
//   - flush: ins_out=0, valid_out=0, nextAddress_out=0; no buffer pop.
//   - stall: all three outputs hold; no pop.
//   - advance, buffer non-empty: pop head into outputs, valid_out=1.
//   - advance, buffer empty: bubble (ins_out=0, valid_out=0); nextAddress_out holds.
//  Buffer:
//   - 2-entry FIFO; push and pop in one cycle are allowed, count unchanged.
//   - Push into a full buffer cannot occur by construction; assert in simulation.
//   - Bypass: data acked while the buffer is empty and advancing is registered into IF/ID on that same edge, zero added latency.
//  Arithmetic: pc and nextAddress are 32-bit, +4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); no alignment check.
//  Mid-operation reset:
//   - Outstanding request is abandoned and req drops asynchronously.
//   - The memory model must tolerate a lost transfer; a late ack after reset release in FETCH/IDLE is ignored.
// TESTING
//  1. Reset release, ack tied 1:
//     - imem_addr 0x3000,0x3004,0x3008 on consecutive cycles.
//     - valid_out=1 from cycle 2; nextAddress_out 0x3004,0x3008,...
//  2. ack every 3rd cycle, stall=0:
//     - single outstanding req, addr stable while waiting.
//     - valid_out pulses 1 per fetch; bubbles ins_out=0 between.
//  3. stall held 5 cycles with ack=1:
//     - buffer fills to 2, req drops.
//     - on stall release, the next 3 outputs are in order, none lost or duplicated.
//  4. redirect to 0x4000 while req to 0x3008 waits (ack 2 cycles later):
//     - addr 0x3008 held until ack, data discarded.
//     - next req addr 0x4000; next valid ins nextAddress_out=0x4004.
//  5. redirect+ack same cycle, plus flush+stall same cycle:
//     - acked word never reaches ins_out.
//     - flush wins: valid_out=0, ins_out=0.
//  6. pc=0xFFFF_FFFC fetch: nextAddress_out=0x0000_0000, next imem_addr=0x0000_0000.
//     Assert reset while WAIT: outputs zero immediately, pc=0x3000.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction-fetch front end: PC, single-outstanding imem req/ack handshake,
// 2-entry prefetch FIFO that absorbs decode stalls, and the IF/ID register.
module if_id_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] ins_out,
   output logic [31:0] nextAddress_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DROP
   } state_e;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] next_addr;
   } entry_t;

   localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   entry_t      buf_q [2];
   entry_t      buf_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] ins_q, ins_d;
   logic [31:0] next_addr_q, next_addr_d;
   logic        valid_q, valid_d;

   logic        xfer;
   logic        ack_keep;
   logic        advance;
   logic        bypass;
   logic        buf_push;
   logic        buf_pop;
   logic [31:0] addr_inc;
   entry_t      head;

   // A word acked in the same cycle as a redirect, or while in DROP, is never kept.
   always_comb begin
      imem_req = (state_q == S_WAIT) || (state_q == S_DROP);
      xfer     = imem_req && imem_ack;
      ack_keep = xfer && (state_q == S_WAIT) && !redirect;
      advance  = !flush && !stall;
      buf_pop  = advance && (count_q != 2'd0);
      bypass   = ack_keep && advance && (count_q == 2'd0);
      buf_push = ack_keep && !bypass;
      addr_inc = addr_q + 32'd4;
      head     = buf_q[rd_ptr_q];
   end

   assign imem_addr = addr_q;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      buf_d    = buf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (buf_push) begin
         buf_d[wr_ptr_q] = '{ins: imem_rdata, next_addr: addr_inc};
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (buf_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, buf_push} - {1'b0, buf_pop};
      if (redirect) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      if (redirect) begin
         pc_d    = redirect_pc;
         state_d = (imem_req && !imem_ack) ? S_DROP : S_FETCH;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
               if (count_q < BUF_FULL) begin
                  addr_d  = pc_q;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (xfer) begin
                  pc_d = pc_q + 32'd4;
                  if (count_d < BUF_FULL) begin
                     addr_d = pc_q + 32'd4;
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            end
            S_DROP: begin
               if (xfer) begin
                  state_d = S_FETCH;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // IF/ID register: flush beats stall beats advance; bypass gives zero-latency delivery.
   always_comb begin
      ins_d       = ins_q;
      next_addr_d = next_addr_q;
      valid_d     = valid_q;
      if (flush) begin
         ins_d       = 32'd0;
         next_addr_d = 32'd0;
         valid_d     = 1'b0;
      end else if (!stall) begin
         if (count_q != 2'd0) begin
            ins_d       = head.ins;
            next_addr_d = head.next_addr;
            valid_d     = 1'b1;
         end else if (bypass) begin
            ins_d       = imem_rdata;
            next_addr_d = addr_inc;
            valid_d     = 1'b1;
         end else begin
            ins_d   = 32'd0;
            valid_d = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses <= so all flops sample pre-edge values together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         ins_q       <= 32'd0;
         next_addr_q <= 32'd0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ins_q       <= ins_d;
         next_addr_q <= next_addr_d;
         valid_q     <= valid_d;
      end
   end

   // NOTE: entry storage has no reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign ins_out         = ins_q;
   assign nextAddress_out = next_addr_q;
   assign valid_out       = valid_q;

   assert property (@(posedge clk) disable iff (!reset) !(buf_push && (count_q == BUF_FULL)));

endmodule
